// File: rtl/axi_pkg.sv
// Shared AXI constants for the SRAM-like to AXI bridges.
package axi_pkg;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam int unsigned AXI_ID_W       = 4;
  localparam int unsigned AXI_LEN_W      = 8;
endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the IF-stage SRAM-like port to an AXI read master.
// Single-beat reads, returned in acceptance order with a one-cycle data_ok.
module inst_sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int unsigned         MAX_OUTSTANDING = 2,
  parameter logic [AXI_ID_W-1:0] AXI_ID          = 4'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_sram_en,
  input  logic                 inst_sram_wen,
  input  logic [1:0]           inst_sram_size,
  input  logic [31:0]          inst_sram_addr,
  input  logic [31:0]          inst_sram_wdata,
  output logic                 inst_sram_addr_ok,
  output logic                 inst_sram_data_ok,
  output logic [31:0]          inst_sram_rdata,
  output logic [AXI_ID_W-1:0]  arid,
  output logic [31:0]          araddr,
  output logic [AXI_LEN_W-1:0] arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [AXI_ID_W-1:0]  rid,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] outstanding;
  logic             r_take;
  logic             unused_inputs;

  // A beat with nothing outstanding is illegal and is dropped rather than counted.
  assign r_take = rvalid && rready && rlast && (outstanding != '0);

  assign inst_sram_addr_ok = !reset && inst_sram_en && !inst_sram_wen &&
                             (!arvalid || arready) &&
                             ((outstanding < CNT_W'(MAX_OUTSTANDING)) || r_take);

  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_W'(0);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  assign unused_inputs = ^{inst_sram_wdata, rid, rresp};

  // AR register slice: holds until handshake, reloads on a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid <= 1'b0;
      araddr  <= '0;
      arsize  <= '0;
    end else if (inst_sram_addr_ok) begin
      arvalid <= 1'b1;
      araddr  <= inst_sram_addr;
      arsize  <= {1'b0, inst_sram_size};
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({inst_sram_addr_ok, r_take})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Return register: no backpressure on data_ok, so it always drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= '0;
    end else begin
      inst_sram_data_ok <= r_take;
      if (r_take) begin
        inst_sram_rdata <= rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rvalid && rlast) begin
      assert (outstanding != '0);
    end
  end

endmodule
